// File: rtl/stage_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and flushable control field.
// Define STAGE_SKID_REG_PERF_EN to add saturating stall/flush performance counters.
`timescale 1ns/1ps
module stage_skid_reg #(
  parameter int unsigned CTRL_W     = 16,
  parameter int unsigned DATA_W     = 128,
  parameter bit          CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef STAGE_SKID_REG_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  logic              main_vld_q, main_vld_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_vld_q, skid_vld_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic accept;
  logic issue;

  // in_ready comes only from the skid flop, so out_ready never reaches it combinationally
  assign in_ready  = ~skid_vld_q;
  assign accept    = in_valid & in_ready;
  assign issue     = main_vld_q & out_ready;

  assign out_valid = main_vld_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

  always_comb begin
    main_vld_d  = main_vld_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_vld_d  = 1'b0;
      main_ctrl_d = '0;
      skid_vld_d  = 1'b0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else if (skid_vld_q) begin
      if (issue) begin
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
        skid_vld_d  = 1'b0;
        skid_ctrl_d = '0;
      end
    end else if (main_vld_q) begin
      if (accept && issue) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else if (accept) begin
        skid_vld_d  = 1'b1;
        skid_ctrl_d = in_ctrl;
        skid_data_d = in_data;
      end else if (issue) begin
        // Data is left in place on drain; only the control field must go quiet
        main_vld_d  = 1'b0;
        main_ctrl_d = '0;
      end
    end else if (accept) begin
      main_vld_d  = 1'b1;
      main_ctrl_d = in_ctrl;
      main_data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_vld_q  <= 1'b0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef STAGE_SKID_REG_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_vld_q && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && main_vld_q && flush_cnt_q != 32'hFFFF_FFFF)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_stage_skid_reg.sv
// Self-checking bench for stage_skid_reg: queue-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_stage_skid_reg;
  localparam int CW = 16;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          in_ready0, in_ready1, out_valid0, out_valid1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [DW-1:0] out_data0, out_data1;
  logic [1:0]    occ0, occ1;
`ifdef STAGE_SKID_REG_PERF_EN
  logic [31:0]   stall0, stall1, fcnt0, fcnt1;
`endif

  stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0)
`ifdef STAGE_SKID_REG_PERF_EN
    , .perf_stall_cnt(stall0), .perf_flush_cnt(fcnt0)
`endif
  );

  stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1)
`ifdef STAGE_SKID_REG_PERF_EN
    , .perf_stall_cnt(stall1), .perf_flush_cnt(fcnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two beats plus the value out_data shows when empty
  logic [CW-1:0] mq_ctrl[$];
  logic [DW-1:0] mq_data[$];
  logic [DW-1:0] hold0 = '0, hold1 = '0;
  logic [31:0]   m_stall = '0, m_flush = '0;
  bit            chk_en = 1'b0;

  task automatic model_step();
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    bit acc, iss;
    if (rst) begin
      mq_ctrl.delete(); mq_data.delete();
      hold0 = '0; hold1 = '0; m_stall = '0; m_flush = '0;
    end else begin
      if (mq_data.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush && mq_data.size() > 0 && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
      if (flush) begin
        if (mq_data.size() > 0) hold0 = mq_data[0];
        hold1 = '0;
        mq_ctrl.delete(); mq_data.delete();
      end else begin
        acc = in_valid && (mq_data.size() < 2);
        iss = (mq_data.size() > 0) && out_ready;
        if (iss) begin
          d = mq_data.pop_front();
          c = mq_ctrl.pop_front();
          if (mq_data.size() == 0) begin hold0 = d; hold1 = d; end
        end
        if (acc) begin
          mq_ctrl.push_back(in_ctrl);
          mq_data.push_back(in_data);
        end
      end
    end
    chk_en = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      automatic int sz = mq_data.size();
      automatic logic [CW-1:0] ec = (sz > 0) ? mq_ctrl[0] : '0;
      check("m_out_valid0", out_valid0, (sz > 0));
      check("m_out_valid1", out_valid1, (sz > 0));
      check("m_out_ctrl0",  out_ctrl0, ec);
      check("m_out_ctrl1",  out_ctrl1, ec);
      check("m_out_data0",  out_data0, (sz > 0) ? mq_data[0] : hold0);
      check("m_out_data1",  out_data1, (sz > 0) ? mq_data[0] : hold1);
      check("m_occ0",       occ0, sz);
      check("m_occ1",       occ1, sz);
      check("m_in_ready0",  in_ready0, (sz < 2));
      check("m_in_ready1",  in_ready1, (sz < 2));
`ifdef STAGE_SKID_REG_PERF_EN
      check("m_stall0", stall0, m_stall);
      check("m_stall1", stall1, m_stall);
      check("m_flush0", fcnt0, m_flush);
      check("m_flush1", fcnt1, m_flush);
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v; in_ctrl = c; in_data = d;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_occ", occ0, 2'd0);
    check("rst_in_ready", in_ready0, 1'b1);
    check("rst_out_ctrl", out_ctrl0, '0);
    check("rst_out_data", out_data0, '0);
    rst = 1'b0;

    // Zero-bubble stream of 1..8
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CW'(i), DW'(i));
      tick();
      check("stream_valid", out_valid0, 1'b1);
      check("stream_data", out_data0, DW'(i));
      check("stream_occ", occ0, 2'd1);
    end
    drive(1'b0, '0, '0);
    tick();
    check("stream_drain", out_valid0, 1'b0);

    // Backpressure fill with A then B
    out_ready = 1'b0;
    drive(1'b1, 16'h000A, DW'(32'hA));
    tick();
    check("bp_one_occ", occ0, 2'd1);
    drive(1'b1, 16'h000B, DW'(32'hB));
    tick();
    check("bp_full_occ", occ0, 2'd2);
    check("bp_full_rdy", in_ready0, 1'b0);
    check("bp_hold_a", out_data0, DW'(32'hA));
    drive(1'b0, '0, '0);
    tick();
    check("bp_hold_a2", out_data0, DW'(32'hA));
    out_ready = 1'b1;
    check("bp_first_a", out_data0, DW'(32'hA));
    tick();
    check("bp_then_b", out_data0, DW'(32'hB));
    check("bp_rdy_back", in_ready0, 1'b1);
    check("bp_occ_one", occ0, 2'd1);
    tick();
    check("bp_empty", out_valid0, 1'b0);

    // Flush while FULL, with a beat offered on the flush cycle
    out_ready = 1'b0;
    drive(1'b1, 16'hFFFF, DW'(32'h11));
    tick();
    drive(1'b1, 16'hFFFF, DW'(32'h22));
    tick();
    check("fl_full", occ0, 2'd2);
    check("fl_ctrl_live", out_ctrl0, 16'hFFFF);
    flush = 1'b1;
    in_valid = 1'b1; in_data = DW'(32'hCC); in_ctrl = 16'h00CC;
    tick();
    flush = 1'b0;
    check("fl_valid", out_valid0, 1'b0);
    check("fl_ctrl0", out_ctrl0, '0);
    check("fl_ctrl1", out_ctrl1, '0);
    check("fl_occ", occ0, 2'd0);
    check("fl_rdy", in_ready0, 1'b1);
    check("fl_data_held", out_data0, DW'(32'h11));
    check("fl_data_clr", out_data1, '0);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_c_gone", out_valid0, 1'b0);
    end

    // Random-gated input with out_ready held high
    for (int i = 0; i < 100; i++) begin
      drive($urandom_range(0, 3) != 0, CW'($urandom), {$urandom, $urandom, $urandom, $urandom});
      tick();
    end

    // Fully random handshakes and occasional flush
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 1) != 0, CW'($urandom), {$urandom, $urandom, $urandom, $urandom});
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;

    // Reset while FULL
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    drive(1'b1, 16'h0101, DW'(32'h101));
    tick();
    drive(1'b1, 16'h0202, DW'(32'h202));
    tick();
    check("rm_full", occ0, 2'd2);
    drive(1'b0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_valid", out_valid0, 1'b0);
    check("rm_ctrl", out_ctrl0, '0);
    check("rm_data", out_data0, '0);
    check("rm_occ", occ0, 2'd0);
    check("rm_rdy", in_ready0, 1'b1);
    out_ready = 1'b1;
    drive(1'b1, 16'h0D0D, DW'(32'hD));
    tick();
    check("rm_d", out_data0, DW'(32'hD));
    check("rm_d_occ", occ0, 2'd1);
    drive(1'b0, '0, '0);
    tick();
    check("rm_d_alone", out_valid0, 1'b0);

`ifdef STAGE_SKID_REG_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, DW'(32'h1));
    tick();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    check("perf_stall", stall0, 32'd5);
    check("perf_flush", fcnt0, 32'd1);
    tick();
    flush = 1'b0;
    check("perf_flush_empty", fcnt0, 32'd1);
    check("perf_stall_keep", stall0, 32'd5);
`else
    check("noperf_idle", out_valid0, 1'b0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/stage_skid_reg.md
Name: stage_skid_reg

Overview:
- Parametrised successor to the fixed ID->EX pipeline register.
- Generic pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer, and separate control and data fields.
- A flush zeroes the control field, so a squashed slot cannot carry live MEM/WB enables.
- Instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) so the core can stall per-stage without combinational ready chains.

Parameters:
- CTRL_W, 16, width of control field (EX_CMD, MEM_R/W_EN, WB_EN, B, S, Imm, status bits...); forced to 0 on flush/reset.
- DATA_W, 128, width of data field (PC, Val_Rn, Val_Rm, immediates, Dest...).
- CLEAR_DATA, 0, 1 = data field also zeroed on flush; 0 = data held (saves toggles).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  squash all held entries (branch taken)
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream data field
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control field, 0 whenever out_valid=0
- out_data  out  DATA_W  data field
- occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Reset: synchronous on rst=1 at posedge clk. out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1, skid cleared. Reset overrides flush and all handshakes.
- Storage: main reg (drives outputs) and skid reg. accept = in_valid & in_ready; issue = out_valid & out_ready.
- States (occupancy):
  - EMPTY(0)
    - accept -> ONE; main loads input.
  - ONE(1)
    - accept & issue -> ONE; main loads input.
    - accept & !issue -> FULL; skid loads input, in_ready falls next cycle.
    - !accept & issue -> EMPTY; out_ctrl <= 0.
    - Otherwise hold.
  - FULL(2); in_ready=0, so no accept.
    - issue -> ONE; main <= skid, skid cleared, in_ready rises next cycle.
    - Otherwise hold.
- Latency: accepted beat appears on out_* the cycle after accept when the stage was EMPTY, or ONE with issue. Zero-bubble throughput of 1 beat/cycle while out_ready=1.
- Ordering: strict FIFO. The skid entry never bypasses main.
- Stability: while out_valid=1 and out_ready=0, out_ctrl/out_data are held unchanged.
- Flush (synchronous, priority over accept/issue):
  - Next cycle out_valid=0, out_ctrl=0, skid invalid, occupancy=0, in_ready=1.
  - Data zeroed only if CLEAR_DATA=1.
  - A beat presented with in_valid on the flush cycle is dropped, not stored.
  - Flush while already EMPTY is a no-op apart from the data clear.
- in_ready depends only on flops; no combinational path from out_ready to in_ready.
- out_valid/out_ctrl/out_data are direct flop outputs.
- Unused: in_ctrl/in_data ignored when in_valid=0 (no X propagation into state).

Optional Feature:
- STAGE_SKID_REG_PERF_EN defined adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt: +1 each cycle out_valid=1 & out_ready=0.
  - perf_flush_cnt: +1 each cycle flush=1 with occupancy!=0.
  - Both counters saturate at 0xFFFFFFFF and reset to 0 on rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then stream: rst 2 cycles; in_valid=1 with data 1..8, out_ready=1 -> out_valid first high 1 cycle after first accept, data 1..8 in order, one per cycle, occupancy stays 1.
- Backpressure fill:
  - In ONE with data=A, out_ready=0, present B -> occupancy=2, in_ready=0 next cycle.
  - out_data holds A; raising out_ready gives A then B on consecutive cycles, in_ready=1 after A issues.
- Flush FULL: FULL with ctrl=0xFFFF, flush=1 and in_valid=1 (C) same cycle -> next cycle out_valid=0, out_ctrl=0, occupancy=0, C never appears; CLEAR_DATA=1 run also shows out_data=0.
- Simultaneous accept+issue in ONE with out_ready=1 for 100 random-gated cycles -> scoreboard matches, never drop/duplicate, occupancy never exceeds 2.
- Reset mid-operation: rst=1 while FULL and flush=0 -> next cycle all outputs at reset values, in_ready=1; following beat D emerges alone.
- PERF (macro on): out_ready=0 for 5 cycles with out_valid=1, then flush while ONE -> perf_stall_cnt=5, perf_flush_cnt=1; flush while EMPTY leaves perf_flush_cnt=1.
